ex_muldiv: RTL

Parametrised iterative multiply/divide unit for the execute stage. It implements the RV32M/RV64M M-extension operations selected by func3. Unlike the single-cycle ALU path, it is multi-cycle: valid/ready handshakes on both sides, flush support, and fast paths for the divide special cases. The hazard unit uses o_busy to stall the pipeline while an operation is in flight.

---
 rtl/ex_muldiv.sv | 113 +++++++++++
 1 files changed

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M/RV64M multiply/divide unit with valid/ready handshakes and flush.
module ex_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_A,
  input  logic [XLEN-1:0] i_B,
  input  logic [2:0]      i_func3,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  state_t state_q, state_d;
  logic [2*XLEN-1:0] acc_q, acc_d, prod;
  logic [XLEN-1:0] b_q, b_d, res_q, res_d, a_mag, b_mag, quo, rem, spec_res;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] f3_q, f3_d;
  logic sa_q, sa_d, sb_q, sb_d, spec_q, spec_d;
  logic accept, sa_in, sb_in, b_zero, ovf, last;
  logic [XLEN:0] mul_sum, div_r, div_diff;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      f3_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      spec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      spec_q  <= spec_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (i_flush) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    state_d = i_valid ? (i_func3[2] ? DIV : MUL) : IDLE;
        MUL,
        DIV:     state_d = last ? DONE : state_q;
        default: state_d = i_ready ? IDLE : DONE;
      endcase
    end
  end
  // Datapath: magnitudes in, shift-add / restoring steps, sign fix on the final edge.
  always_comb begin
    accept   = i_valid && state_q == IDLE && !i_flush;
    sa_in    = i_A[XLEN-1] & (i_func3[2] ? ~i_func3[0] : i_func3 != 3'b011);
    sb_in    = i_B[XLEN-1] & (i_func3[2] ? ~i_func3[0] : ~i_func3[1]);
    a_mag    = sa_in ? -i_A : i_A;
    b_mag    = sb_in ? -i_B : i_B;
    b_zero   = i_B == '0;
    ovf      = !i_func3[0] && i_A == MIN && i_B == '1;
    spec_res = b_zero ? (i_func3[1] ? i_A : '1) : (i_func3[1] ? '0 : MIN);
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_r    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_r - {1'b0, b_q};
    prod     = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo      = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem      = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    last     = spec_q || cnt_q == CNT_W'(XLEN);
    acc_d    = acc_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    spec_d   = spec_q;
    if (accept) begin
      acc_d  = {{XLEN{1'b0}}, a_mag};
      b_d    = b_mag;
      cnt_d  = '0;
      f3_d   = i_func3;
      sa_d   = sa_in;
      sb_d   = sb_in;
      spec_d = i_func3[2] && (b_zero || ovf);
      res_d  = spec_d ? spec_res : res_q;
    end else if ((state_q == MUL || state_q == DIV) && !last) begin
      cnt_d = cnt_q + 1'b1;
      acc_d = state_q == MUL ? {mul_sum, acc_q[XLEN-1:1]}
            : {div_diff[XLEN] ? div_r[XLEN-1:0] : div_diff[XLEN-1:0], acc_q[XLEN-2:0], ~div_diff[XLEN]};
    end else if ((state_q == MUL || state_q == DIV) && !spec_q) begin
      res_d = state_q == MUL ? (f3_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
            : (f3_q[1] ? rem : quo);
    end
  end
  always_comb begin
    o_ready  = state_q == IDLE && i_rst_n;
    o_busy   = state_q != IDLE;
    o_valid  = state_q == DONE;
    o_result = res_q;
  end
endmodule
